// File: rtl/seg7_hex_reader.sv
// rtl/seg7_hex_reader.sv - debounced seven-segment pattern to hex digit reader
module seg7_hex_reader #(
    parameter int unsigned STABLE_CNT = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] seg_in,
    input  logic       seg_valid,
    output logic [3:0] hex_out,
    output logic       err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun
);

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    logic [6:0] pat;
    logic [3:0] dec_hex;
    logic       dec_err;

    logic [6:0] last_pat_q, last_pat_d;
    logic [3:0] cnt_q, cnt_d;
    logic       match;
    logic       accept;

    logic [3:0] hex_q, hex_d;
    logic       err_q, err_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;
    logic       xfer;

    // Polarity normalisation so the rest of the logic is always active-high
    assign pat = ACTIVE_LOW ? ~seg_in : seg_in;

    // Glyph lookup; anything that is not one of the sixteen glyphs is an error with digit 0
    always_comb begin
        dec_hex = 4'h0;
        dec_err = 1'b0;
        unique case (pat)
            7'h3F:   dec_hex = 4'h0;
            7'h06:   dec_hex = 4'h1;
            7'h5B:   dec_hex = 4'h2;
            7'h4F:   dec_hex = 4'h3;
            7'h66:   dec_hex = 4'h4;
            7'h6D:   dec_hex = 4'h5;
            7'h7D:   dec_hex = 4'h6;
            7'h07:   dec_hex = 4'h7;
            7'h7F:   dec_hex = 4'h8;
            7'h6F:   dec_hex = 4'h9;
            7'h77:   dec_hex = 4'hA;
            7'h7C:   dec_hex = 4'hB;
            7'h39:   dec_hex = 4'hC;
            7'h5E:   dec_hex = 4'hD;
            7'h79:   dec_hex = 4'hE;
            7'h71:   dec_hex = 4'hF;
            default: begin
                dec_hex = 4'h0;
                dec_err = 1'b1;
            end
        endcase
    end

    // Run filter: count identical valid samples, saturating, and flag the sample that completes a run.
    // A pattern change restarts the run at 1, which itself completes a run when STABLE_CNT is 1.
    always_comb begin
        last_pat_d = last_pat_q;
        cnt_d      = cnt_q;
        match      = (pat == last_pat_q);
        accept     = 1'b0;
        if (seg_valid) begin
            if (match) begin
                if (cnt_q < STABLE) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                last_pat_d = pat;
                cnt_d      = 4'd1;
            end
            accept = (cnt_d == STABLE) && (!match || (cnt_q < STABLE));
        end
    end

    // Output slot: load on accept when the slot is free or being drained, otherwise drop and flag overrun
    always_comb begin
        hex_d     = hex_q;
        err_d     = err_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        xfer      = valid_q && out_ready;
        if (accept) begin
            if (!valid_q || out_ready) begin
                hex_d   = dec_hex;
                err_d   = dec_err;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_pat_q <= 7'h00;
            cnt_q      <= 4'd0;
            hex_q      <= 4'h0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            last_pat_q <= last_pat_d;
            cnt_q      <= cnt_d;
            hex_q      <= hex_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign hex_out   = hex_q;
    assign err       = err_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_hex_reader.sv
// tb/tb_seg7_hex_reader.sv - self-checking bench for seg7_hex_reader
module tb_seg7_hex_reader;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic       seg_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] hex_out;
    logic       err, out_valid, overrun;

    logic [6:0] seg2 = 7'h00;
    logic       v2 = 1'b0;
    logic       rdy2 = 1'b1;
    logic [3:0] hex2;
    logic       err2, valid2, ovr2;

    int total = 0;
    int bad = 0;

    // reference model state
    logic [6:0] m_last;
    int         m_run;
    logic       m_valid, m_err, m_ovr;
    logic [3:0] m_hex;
    logic [6:0] glyph [16];

    typedef struct {
        logic       v;
        logic [6:0] p;
        logic       rdy;
        logic       ev;
        logic [3:0] eh;
        logic       ee;
        logic       eo;
    } vec_t;
    vec_t tbl [$];

    always #5 clk = ~clk;

    seg7_hex_reader #(.STABLE_CNT(STABLE), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .seg_valid(seg_valid),
        .hex_out(hex_out), .err(err), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun)
    );

    seg7_hex_reader #(.STABLE_CNT(1), .ACTIVE_LOW(1'b1)) dut2 (
        .clk(clk), .reset_n(reset_n), .seg_in(seg2), .seg_valid(v2),
        .hex_out(hex2), .err(err2), .out_valid(valid2),
        .out_ready(rdy2), .overrun(ovr2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_decode(input logic [6:0] p, output logic [3:0] h, output logic e);
        h = 4'h0;
        e = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == p) begin
                h = 4'(i);
                e = 1'b0;
            end
        end
    endtask

    // called at a negedge: drive inputs, advance the model, move to the next negedge
    task automatic tick(input logic v, input logic [6:0] p, input logic rdy);
        logic acc;
        seg_in    = p;
        seg_valid = v;
        out_ready = rdy;
        acc = 1'b0;
        if (v) begin
            if (p == m_last) m_run++;
            else begin
                m_last = p;
                m_run  = 1;
            end
            acc = (m_run == STABLE);
        end
        if (acc) begin
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                model_decode(p, m_hex, m_err);
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_last = 7'h00;
        m_run = 0;
        m_valid = 1'b0;
        m_hex = 4'h0;
        m_err = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic do_reset();
        seg_valid = 1'b0;
        v2 = 1'b0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
        if (m_valid) begin
            chk({tag, ".hex"}, 32'(hex_out), 32'(m_hex));
            chk({tag, ".err"}, 32'(err), 32'(m_err));
        end
    endtask

    function automatic vec_t mk(logic v, logic [6:0] p, logic ev, logic [3:0] eh, logic ee);
        vec_t r;
        r.v = v; r.p = p; r.rdy = 1'b1; r.ev = ev; r.eh = eh; r.ee = ee; r.eo = 1'b0;
        return r;
    endfunction

    initial begin
        logic [6:0] cur;
        logic [6:0] pool [4];
        logic       v, rdy;

        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        // four 5B then a fifth
        repeat (3) tbl.push_back(mk(1, 7'h5B, 0, 0, 0));
        tbl.push_back(mk(1, 7'h5B, 1, 4'h2, 0));
        tbl.push_back(mk(1, 7'h5B, 0, 0, 0));
        // 06,06 then 07 x4 with idle gaps
        tbl.push_back(mk(1, 7'h06, 0, 0, 0));
        tbl.push_back(mk(0, 7'h00, 0, 0, 0));
        tbl.push_back(mk(1, 7'h06, 0, 0, 0));
        tbl.push_back(mk(0, 7'h00, 0, 0, 0));
        tbl.push_back(mk(1, 7'h07, 0, 0, 0));
        tbl.push_back(mk(1, 7'h07, 0, 0, 0));
        tbl.push_back(mk(0, 7'h00, 0, 0, 0));
        tbl.push_back(mk(1, 7'h07, 0, 0, 0));
        tbl.push_back(mk(1, 7'h07, 1, 4'h7, 0));
        tbl.push_back(mk(0, 7'h00, 0, 0, 0));
        // illegal glyph 01
        repeat (3) tbl.push_back(mk(1, 7'h01, 0, 0, 0));
        tbl.push_back(mk(1, 7'h01, 1, 4'h0, 1));
        tbl.push_back(mk(0, 7'h00, 0, 0, 0));

        model_reset();
        @(negedge clk);
        chk("reset.valid", 32'(out_valid), 32'd0);
        chk("reset.hex", 32'(hex_out), 32'd0);
        chk("reset.err", 32'(err), 32'd0);
        chk("reset.overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].v, tbl[i].p, tbl[i].rdy);
            chk($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d.overrun", i), 32'(overrun), 32'(tbl[i].eo));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d.hex", i), 32'(hex_out), 32'(tbl[i].eh));
                chk($sformatf("tbl%0d.err", i), 32'(err), 32'(tbl[i].ee));
            end
        end

        // held result, overrun on a second run, then drain
        do_reset();
        repeat (4) tick(1, 7'h3F, 0);
        chk("hold.valid", 32'(out_valid), 32'd1);
        chk("hold.hex", 32'(hex_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(1, 7'h06, 0);
            chk($sformatf("hold%0d.hex", i), 32'(hex_out), 32'd0);
            chk($sformatf("hold%0d.valid", i), 32'(out_valid), 32'd1);
        end
        chk("ovr.set", 32'(overrun), 32'd1);
        tick(0, 7'h00, 1);
        chk("drain.valid", 32'(out_valid), 32'd0);
        chk("drain.overrun", 32'(overrun), 32'd1);
        repeat (2) tick(0, 7'h00, 1);
        chk("ovr.sticky", 32'(overrun), 32'd1);

        // asynchronous reset clears outputs without a clock edge
        reset_n = 1'b0;
        #1;
        chk("async.overrun", 32'(overrun), 32'd0);
        chk("async.valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // partial run discarded by reset
        repeat (3) tick(1, 7'h7F, 1);
        reset_n = 1'b0;
        #1;
        chk("mid.hex", 32'(hex_out), 32'd0);
        chk("mid.err", 32'(err), 32'd0);
        chk("mid.valid", 32'(out_valid), 32'd0);
        chk("mid.overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        tick(1, 7'h7F, 1);
        for (int i = 0; i < 4; i++) begin
            tick(0, 7'h00, 1);
            chk($sformatf("mid%0d.noresult", i), 32'(out_valid), 32'd0);
        end

        // first sample 00 after reset counts as a match: three more complete the run
        do_reset();
        tick(1, 7'h00, 1);
        tick(1, 7'h00, 1);
        tick(1, 7'h00, 1);
        chk("zero.pending", 32'(out_valid), 32'd0);
        tick(1, 7'h00, 1);
        chk("zero.valid", 32'(out_valid), 32'd1);
        chk("zero.err", 32'(err), 32'd1);

        // active-low, single-sample instance
        do_reset();
        seg2 = 7'h00;
        v2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v2 = 1'b0;
        chk("al.valid", 32'(valid2), 32'd1);
        chk("al.hex", 32'(hex2), 32'd8);
        chk("al.err", 32'(err2), 32'd0);
        seg2 = 7'h79;
        v2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v2 = 1'b0;
        chk("al2.valid", 32'(valid2), 32'd1);
        chk("al2.hex", 32'(hex2), 32'd1);
        chk("al2.overrun", 32'(ovr2), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("al2.drain", 32'(valid2), 32'd0);

        // randomized run against the model
        do_reset();
        pool = '{7'h5B, 7'h3F, 7'h00, 7'h2A};
        cur = pool[0];
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 4) == 0) cur = 7'($urandom_range(0, 127));
                else cur = pool[$urandom_range(0, 3)];
            end
            v   = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 6);
            tick(v, cur, rdy);
            check_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
